// File: rtl/game_sequencer_if.sv
// Signal bundle between the game sequencer and its surroundings (video timing,
// ball engine, buttons, score display).
interface game_sequencer_if;
    logic       i_VSync;
    logic       i_Start;
    logic       i_Miss_Left;
    logic       i_Miss_Right;
    logic       o_Ball_Enable;
    logic       o_Ball_Reset;
    logic       o_Serve_Dir;
    logic [3:0] o_Score_Left;
    logic [3:0] o_Score_Right;
    logic       o_Game_Over;
    logic [2:0] o_State;
    logic       o_Frame_Tick;

    modport master (
        output i_VSync, i_Start, i_Miss_Left, i_Miss_Right,
        input  o_Ball_Enable, o_Ball_Reset, o_Serve_Dir, o_Score_Left,
        input  o_Score_Right, o_Game_Over, o_State, o_Frame_Tick
    );

    modport slave (
        input  i_VSync, i_Start, i_Miss_Left, i_Miss_Right,
        output o_Ball_Enable, o_Ball_Reset, o_Serve_Dir, o_Score_Left,
        output o_Score_Right, o_Game_Over, o_State, o_Frame_Tick
    );
endinterface

// File: rtl/game_sequencer.sv
// Pong-style game flow: idle, serve hold, play, point pause and game over,
// paced by frame ticks taken from the falling edge of VSync.
module game_sequencer #(
    parameter int SERVE_FRAMES  = 60,
    parameter int SCORED_FRAMES = 90,
    parameter int WIN_SCORE     = 9
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    game_sequencer_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SERVE  = 3'd1,
        PLAY   = 3'd2,
        SCORED = 3'd3,
        OVER   = 3'd4
    } state_t;

    localparam logic [7:0] SERVE_N  = 8'(SERVE_FRAMES);
    localparam logic [7:0] SCORED_N = 8'(SCORED_FRAMES);
    localparam logic [3:0] WIN_N    = 4'(WIN_SCORE);

    // Output mode word: {ball_enable, ball_reset, game_over}
    function automatic logic [2:0] mode_of(input state_t s);
        case (s)
            PLAY:    return 3'b100;
            OVER:    return 3'b011;
            default: return 3'b010;
        endcase
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s == 4'hF) ? s : s + 4'd1;
    endfunction

    state_t     state;
    logic [2:0] mode;
    logic [7:0] cnt;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic       serve_dir;
    logic       vsync_p1;
    logic       start_p1;
    logic       start_armed;
    logic       tick_p1;
    logic       frame_tick;
    logic       start_ev;

    // A button still held when reset releases stays disarmed until it is let go.
    assign frame_tick = vsync_p1 & ~bus.i_VSync;
    assign start_ev   = bus.i_Start & ~start_p1 & start_armed;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state       <= IDLE;
            mode        <= mode_of(IDLE);
            cnt         <= 8'd0;
            score_l     <= 4'd0;
            score_r     <= 4'd0;
            serve_dir   <= 1'b0;
            vsync_p1    <= 1'b1;
            start_p1    <= 1'b0;
            start_armed <= ~bus.i_Start;
            tick_p1     <= 1'b0;
        end else begin
            vsync_p1 <= bus.i_VSync;
            start_p1 <= bus.i_Start;
            tick_p1  <= frame_tick;
            if (!bus.i_Start) start_armed <= 1'b1;

            case (state)
                IDLE: begin
                    if (start_ev) begin
                        score_l   <= 4'd0;
                        score_r   <= 4'd0;
                        serve_dir <= 1'b0;
                        cnt       <= 8'd0;
                        state     <= SERVE;
                        mode      <= mode_of(SERVE);
                    end
                end
                SERVE: begin
                    if (frame_tick) begin
                        if (cnt + 8'd1 == SERVE_N) begin
                            cnt   <= 8'd0;
                            state <= PLAY;
                            mode  <= mode_of(PLAY);
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                PLAY: begin
                    // Simultaneous misses are a void rally: re-serve the other way.
                    if (bus.i_Miss_Left && bus.i_Miss_Right) begin
                        serve_dir <= ~serve_dir;
                        cnt       <= 8'd0;
                        state     <= SERVE;
                        mode      <= mode_of(SERVE);
                    end else if (bus.i_Miss_Left) begin
                        score_r   <= sat_inc(score_r);
                        serve_dir <= 1'b0;
                        cnt       <= 8'd0;
                        state     <= SCORED;
                        mode      <= mode_of(SCORED);
                    end else if (bus.i_Miss_Right) begin
                        score_l   <= sat_inc(score_l);
                        serve_dir <= 1'b1;
                        cnt       <= 8'd0;
                        state     <= SCORED;
                        mode      <= mode_of(SCORED);
                    end
                end
                SCORED: begin
                    if (frame_tick) begin
                        if (cnt + 8'd1 == SCORED_N) begin
                            cnt <= 8'd0;
                            if (score_l == WIN_N || score_r == WIN_N) begin
                                state <= OVER;
                                mode  <= mode_of(OVER);
                            end else begin
                                state <= SERVE;
                                mode  <= mode_of(SERVE);
                            end
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                OVER: begin
                    if (start_ev) begin
                        score_l <= 4'd0;
                        score_r <= 4'd0;
                        cnt     <= 8'd0;
                        state   <= SERVE;
                        mode    <= mode_of(SERVE);
                    end
                end
                default: begin
                    state <= IDLE;
                    mode  <= mode_of(IDLE);
                end
            endcase
        end
    end

    assign bus.o_Ball_Enable = mode[2];
    assign bus.o_Ball_Reset  = mode[1];
    assign bus.o_Game_Over   = mode[0];
    assign bus.o_Serve_Dir   = serve_dir;
    assign bus.o_Score_Left  = score_l;
    assign bus.o_Score_Right = score_r;
    assign bus.o_State       = state;
    assign bus.o_Frame_Tick  = tick_p1;
endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with SERVE_FRAMES=2, SCORED_FRAMES=1, WIN_SCORE=2.
module tb_game_sequencer;
    localparam logic [2:0] S_IDLE = 3'd0, S_SERVE = 3'd1, S_PLAY = 3'd2,
                           S_SCORED = 3'd3, S_OVER = 3'd4;

    typedef struct packed {
        logic [2:0] st;
        logic [3:0] sl;
        logic [3:0] sr;
        logic       dir;
        logic       tick;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];

    game_sequencer_if bus();

    game_sequencer #(
        .SERVE_FRAMES (2),
        .SCORED_FRAMES(1),
        .WIN_SCORE    (2)
    ) dut (
        .i_Clk(clk),
        .i_Rst(rst),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Drive one cycle of inputs, queue the expected outputs for after the edge,
    // then pop and compare once the DUT has clocked.
    task automatic cyc(input logic vs, input logic st, input logic ml, input logic mr,
                       input logic [2:0] es, input logic [3:0] esl, input logic [3:0] esr,
                       input logic ed, input logic et, input string tag);
        exp_t e;
        bus.i_VSync      = vs;
        bus.i_Start      = st;
        bus.i_Miss_Left  = ml;
        bus.i_Miss_Right = mr;
        exp_q.push_back('{st: es, sl: esl, sr: esr, dir: ed, tick: et});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({tag, ".state"},      {1'b0, bus.o_State},        {1'b0, e.st});
        chk({tag, ".score_l"},    bus.o_Score_Left,            e.sl);
        chk({tag, ".score_r"},    bus.o_Score_Right,           e.sr);
        chk({tag, ".serve_dir"},  {3'b0, bus.o_Serve_Dir},     {3'b0, e.dir});
        chk({tag, ".ball_en"},    {3'b0, bus.o_Ball_Enable},   {3'b0, e.st == S_PLAY});
        chk({tag, ".ball_rst"},   {3'b0, bus.o_Ball_Reset},    {3'b0, e.st != S_PLAY});
        chk({tag, ".game_over"},  {3'b0, bus.o_Game_Over},     {3'b0, e.st == S_OVER});
        chk({tag, ".frame_tick"}, {3'b0, bus.o_Frame_Tick},    {3'b0, e.tick});
    endtask

    initial begin
        bus.i_VSync      = 1'b1;
        bus.i_Start      = 1'b0;
        bus.i_Miss_Left  = 1'b0;
        bus.i_Miss_Right = 1'b0;

        rst = 1'b1;
        cyc(1, 0, 0, 0, S_IDLE,   0, 0, 0, 0, "reset");
        rst = 1'b0;
        cyc(1, 1, 0, 0, S_SERVE,  0, 0, 0, 0, "start");
        cyc(0, 1, 0, 0, S_SERVE,  0, 0, 0, 1, "serve_tick1");
        cyc(1, 0, 0, 0, S_SERVE,  0, 0, 0, 0, "serve_gap1");
        cyc(0, 0, 0, 0, S_PLAY,   0, 0, 0, 1, "serve_to_play");
        cyc(1, 0, 1, 0, S_SCORED, 0, 1, 0, 0, "miss_left");
        cyc(0, 0, 0, 0, S_SERVE,  0, 1, 0, 1, "scored_to_serve");
        cyc(1, 0, 0, 0, S_SERVE,  0, 1, 0, 0, "serve_gap2");
        cyc(0, 0, 0, 0, S_SERVE,  0, 1, 0, 1, "serve_tick2");
        cyc(1, 0, 1, 0, S_SERVE,  0, 1, 0, 0, "miss_in_serve");
        cyc(0, 0, 0, 0, S_PLAY,   0, 1, 0, 1, "play2");
        cyc(1, 0, 1, 1, S_SERVE,  0, 1, 1, 0, "both_miss");
        cyc(0, 0, 0, 0, S_SERVE,  0, 1, 1, 1, "serve_tick3");
        cyc(1, 0, 0, 0, S_SERVE,  0, 1, 1, 0, "serve_gap3");
        cyc(0, 0, 0, 0, S_PLAY,   0, 1, 1, 1, "play3");
        cyc(1, 0, 0, 0, S_PLAY,   0, 1, 1, 0, "play_hold");
        cyc(0, 0, 0, 1, S_SCORED, 1, 1, 1, 1, "tick_and_miss_right");
        cyc(1, 0, 1, 0, S_SCORED, 1, 1, 1, 0, "miss_in_scored");
        cyc(0, 0, 0, 0, S_SERVE,  1, 1, 1, 1, "scored_to_serve2");
        cyc(1, 0, 0, 0, S_SERVE,  1, 1, 1, 0, "serve_gap4");
        cyc(0, 0, 0, 0, S_SERVE,  1, 1, 1, 1, "serve_tick4");
        cyc(1, 0, 0, 0, S_SERVE,  1, 1, 1, 0, "serve_gap5");
        cyc(0, 0, 0, 0, S_PLAY,   1, 1, 1, 1, "play4");
        cyc(1, 0, 1, 0, S_SCORED, 1, 2, 0, 0, "miss_left2");
        cyc(0, 1, 0, 0, S_OVER,   1, 2, 0, 1, "game_over");
        cyc(1, 1, 0, 0, S_OVER,   1, 2, 0, 0, "start_held1");
        cyc(1, 1, 0, 0, S_OVER,   1, 2, 0, 0, "start_held2");
        cyc(1, 0, 0, 0, S_OVER,   1, 2, 0, 0, "start_release");
        cyc(1, 1, 0, 0, S_SERVE,  0, 0, 0, 0, "restart");
        cyc(1, 0, 0, 0, S_SERVE,  0, 0, 0, 0, "serve_gap6");
        cyc(0, 0, 0, 0, S_SERVE,  0, 0, 0, 1, "serve_tick5");
        cyc(1, 0, 0, 0, S_SERVE,  0, 0, 0, 0, "serve_gap7");

        rst = 1'b1;
        cyc(0, 1, 0, 0, S_IDLE,   0, 0, 0, 0, "reset_mid_serve");
        rst = 1'b0;
        cyc(1, 1, 0, 0, S_IDLE,   0, 0, 0, 0, "start_held_after_reset");
        cyc(1, 1, 1, 1, S_IDLE,   0, 0, 0, 0, "miss_in_idle");
        cyc(1, 0, 0, 0, S_IDLE,   0, 0, 0, 0, "start_release2");
        cyc(1, 1, 0, 0, S_SERVE,  0, 0, 0, 0, "start_after_release");
        cyc(0, 1, 0, 0, S_SERVE,  0, 0, 0, 1, "serve_tick6");
        cyc(1, 0, 0, 0, S_SERVE,  0, 0, 0, 0, "serve_gap8");
        cyc(0, 0, 0, 0, S_PLAY,   0, 0, 0, 1, "play5");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 The block SHALL have parameter SERVE_FRAMES, default 60: frames the ball is held at centre before play.
REQ-002 The block SHALL have parameter SCORED_FRAMES, default 90: pause frames after a point.
REQ-003 The block SHALL have parameter WIN_SCORE, default 9, range 1..15: score that ends the game.
REQ-004 Port i_Clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 Port i_Rst, input, 1: reset, synchronous and active-high.
REQ-006 Port i_VSync, input, 1: VGA vertical sync, active-low, synchronous to i_Clk.
REQ-007 Port i_Start, input, 1: start button, level, already debounced.
REQ-008 Port i_Miss_Left, input, 1: one-cycle pulse, ball passed the left edge.
REQ-009 Port i_Miss_Right, input, 1: one-cycle pulse, ball passed the right edge.
REQ-010 Port o_Ball_Enable, output, 1: ball may move.
REQ-011 Port o_Ball_Reset, output, 1: ball is held at screen centre.
REQ-012 Port o_Serve_Dir, output, 1: initial ball direction (0 = toward left, 1 = toward right).
REQ-013 Ports o_Score_Left and o_Score_Right, output, 4 each: player scores.
REQ-014 Port o_Game_Over, output, 1: a player has reached WIN_SCORE.
REQ-015 Port o_State, output, 3: current state encoding.
REQ-016 Port o_Frame_Tick, output, 1: one-cycle pulse at the start of each frame.

Function
REQ-017 The frame tick SHALL be derived from a registered copy of i_VSync and SHALL pulse for exactly one cycle, on the cycle after i_VSync is sampled 0 when its registered copy is 1.
REQ-018 Start SHALL be edge-detected, with a registered copy of i_Start; a start event SHALL occur when i_Start = 1 and the previous sample = 0; a held button SHALL NOT generate repeat events.
REQ-019 The state encodings SHALL be IDLE=0, SERVE=1, PLAY=2, SCORED=3, OVER=4; values 5..7 SHALL go to IDLE on the next clock.
REQ-020 IDLE: o_Ball_Reset=1, o_Ball_Enable=0; a start event SHALL clear both scores, set o_Serve_Dir=0, clear the frame counter, and go to SERVE.
REQ-021 SERVE: o_Ball_Reset=1, o_Ball_Enable=0; each frame tick SHALL increment the frame counter; the tick that brings the count to SERVE_FRAMES SHALL clear the counter and go to PLAY.
REQ-022 PLAY: o_Ball_Reset=0, o_Ball_Enable=1.
REQ-023 In PLAY, i_Miss_Left alone SHALL increment o_Score_Right, set o_Serve_Dir=0, and go to SCORED.
REQ-024 In PLAY, i_Miss_Right alone SHALL increment o_Score_Left, set o_Serve_Dir=1, and go to SCORED.
REQ-025 In PLAY, both misses in the same cycle SHALL leave both scores unchanged, toggle o_Serve_Dir, and go to SERVE with the counter cleared.
REQ-026 SCORED: o_Ball_Reset=1, o_Ball_Enable=0; the counter SHALL count frame ticks up to SCORED_FRAMES, then clear and go to OVER if either score equals WIN_SCORE, otherwise to SERVE.
REQ-027 OVER: o_Game_Over=1, o_Ball_Reset=1, o_Ball_Enable=0; scores are held; a start event SHALL clear the scores and go to SERVE.
REQ-028 Miss pulses outside PLAY SHALL be ignored; start events outside IDLE and OVER SHALL be ignored.
REQ-029 Scores SHALL saturate at 15 and never wrap.
REQ-030 The frame counter SHALL be 8 bits wide; SERVE_FRAMES and SCORED_FRAMES SHALL be limited to 1..255.
REQ-031 All outputs SHALL be registered; each output SHALL reflect the new state one clock after the cycle in which the causing input was sampled.
REQ-032 A frame tick and a miss pulse in the same PLAY cycle SHALL behave as the miss alone.

Reset
REQ-033 While i_Rst=1 on a clock edge, the block SHALL go to IDLE, with scores=0, o_Serve_Dir=0, counter=0, edge-detect registers=1 (VSync) and 0 (Start), o_Ball_Reset=1, o_Ball_Enable=0, o_Game_Over=0, o_Frame_Tick=0, o_State=0.
REQ-034 Reset asserted in any state, including mid-count, SHALL take full effect on that edge; no start event SHALL be inferred from i_Start already high when reset releases.

Verification (SERVE_FRAMES=2, SCORED_FRAMES=1, WIN_SCORE=2)
REQ-035 Reset, start pulse, 2 VSync falling edges -> SERVE then PLAY after the second tick; o_Ball_Enable=1, scores 0/0.
REQ-036 PLAY, i_Miss_Left pulse -> o_Score_Right=1, o_Serve_Dir=0, SCORED; after 1 tick, SERVE.
REQ-037 PLAY, both misses in one cycle -> scores unchanged, o_Serve_Dir toggles, SERVE.
REQ-038 Right player scores twice -> after SCORED, OVER with o_Game_Over=1; i_Start held high -> stays OVER; release then press -> scores 0/0, SERVE.
REQ-039 i_Rst pulsed mid-SERVE with counter=1 -> IDLE on that edge, all outputs at reset values; i_Start held high through reset -> stays IDLE.
REQ-040 Miss pulses in IDLE, SERVE and SCORED -> no score change, no state change.
